// File: rtl/sine_meter_pkg.sv
`default_nettype none
// ============================================================================
// Package : sine_meter_pkg
// Brief   : Shared state and level encodings for the sine period meter.
// Rev     : 1.0 - initial release
// ============================================================================
package sine_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    typedef enum logic [1:0] {
        LVL_UNKNOWN = 2'd0,
        LVL_LOW     = 2'd1,
        LVL_HIGH    = 2'd2
    } level_t;

endpackage : sine_meter_pkg
`default_nettype wire

// File: rtl/sine_period_meter_crossing.sv
`default_nettype none
// ============================================================================
// Module : hysteresis_crossing
// Brief  : Midscale level tracker with hysteresis; flags LOW->HIGH transitions.
// Rev    : 1.0 - initial release
// ============================================================================
module hysteresis_crossing
    import sine_meter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HYST  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             rise
);

    localparam int             c_MID   = 2 ** (WIDTH - 1);
    // One extra bit so the band edges never wrap for large HYST.
    localparam logic [WIDTH:0] c_HI_TH = (WIDTH + 1)'(c_MID + HYST);
    localparam logic [WIDTH:0] c_LO_TH = (WIDTH + 1)'(c_MID - HYST);

    level_t r_level;
    logic   w_above;
    logic   w_below;

    assign w_above = ({1'b0, sample} >= c_HI_TH);
    assign w_below = ({1'b0, sample} <  c_LO_TH);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_level <= LVL_UNKNOWN;
        end else if (sample_valid) begin
            if (w_above) begin
                r_level <= LVL_HIGH;
            end else if (w_below) begin
                r_level <= LVL_LOW;
            end
        end
    end

    // UNKNOWN->HIGH deliberately does not count as a rising event.
    assign rise = sample_valid && (r_level == LVL_LOW) && w_above;

endmodule : hysteresis_crossing
`default_nettype wire

// File: rtl/sine_period_meter.sv
`default_nettype none
// ============================================================================
// Module : sine_period_meter
// Brief  : Measures clk-cycle period and peak/trough between rising crossings.
// Rev    : 1.0 - initial release
// ============================================================================
module sine_period_meter
    import sine_meter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 24,
    parameter int HYST        = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   sample_valid,
    input  logic [WIDTH-1:0]       sample,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [WIDTH-1:0]       peak,
    output logic [WIDTH-1:0]       trough,
    output logic                   result_valid,
    output logic                   timeout
);

    localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX = '1;

    meter_state_t           r_state;
    meter_state_t           w_next_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [WIDTH-1:0]       r_peak_trk;
    logic [WIDTH-1:0]       r_trough_trk;
    logic                   w_rise;
    logic                   w_clear;
    logic                   w_sat;
    logic                   w_start;
    logic                   w_report;
    logic                   w_expire;
    logic [WIDTH-1:0]       w_peak_new;
    logic [WIDTH-1:0]       w_trough_new;

    assign w_sat    = (r_count == c_CNT_MAX);
    assign w_start  = enable && (r_state == SEEK) && w_rise;
    assign w_report = enable && (r_state == MEASURE) && w_rise;
    assign w_expire = enable && (r_state == MEASURE) && !w_rise && w_sat;

    // Level goes back to UNKNOWN whenever we (re)enter SEEK or sit idle.
    assign w_clear  = (r_state == IDLE) || !enable || w_expire;

    assign w_peak_new   = (sample > r_peak_trk)   ? sample : r_peak_trk;
    assign w_trough_new = (sample < r_trough_trk) ? sample : r_trough_trk;

    hysteresis_crossing #(
        .WIDTH (WIDTH),
        .HYST  (HYST)
    ) u_crossing (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (w_clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .rise         (w_rise)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = SEEK;
            SEEK:    if (w_rise) w_next_state = MEASURE;
            MEASURE: if (!w_rise && w_sat) w_next_state = SEEK;
            default: w_next_state = IDLE;
        endcase
        if (!enable) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_peak_trk   <= '0;
            r_trough_trk <= '0;
            period       <= '0;
            peak         <= '0;
            trough       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (!enable || (r_state == IDLE)) begin
                r_count <= '0;
            end else if (w_start) begin
                r_count      <= COUNT_WIDTH'(1);
                r_peak_trk   <= sample;
                r_trough_trk <= sample;
            end else if (r_state == MEASURE) begin
                if (w_report) begin
                    // Event beats saturation on the same edge.
                    period       <= r_count;
                    peak         <= w_peak_new;
                    trough       <= w_trough_new;
                    result_valid <= 1'b1;
                    r_count      <= COUNT_WIDTH'(1);
                    r_peak_trk   <= sample;
                    r_trough_trk <= sample;
                end else if (w_expire) begin
                    timeout <= 1'b1;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                    if (sample_valid) begin
                        r_peak_trk   <= w_peak_new;
                        r_trough_trk <= w_trough_new;
                    end
                end
            end
        end
    end

endmodule : sine_period_meter
`default_nettype wire
